jtpopeye_rom_arb: RTL

- Shares the single 32-bit SDRAM read port between three ROM clients: main CPU ROM, object (sprite) ROM and character ROM.
- Each client gets a one-entry tagged word cache. Repeat reads of the same address are served without touching SDRAM.
- Sits between the game core (jtpopeye_obj, character generator, CPU) and the SDRAM controller.
- Fixed priority, non-preemptive, one SDRAM transaction outstanding at a time.

---
 rtl/jtpopeye_rom_arb.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/jtpopeye_rom_arb.sv
`default_nettype none
// ============================================================================
// Module   : jtpopeye_rom_arb
// Brief    : Fixed-priority arbiter giving main, object and character ROM
//            clients a shared SDRAM read port, each behind a one-word cache.
// Revision : 1.0 - initial release
// ============================================================================
module jtpopeye_rom_arb #(
  parameter int          MAIN_AW   = 13,
  parameter int          OBJ_AW    = 13,
  parameter int          CHR_AW    = 11,
  parameter logic [21:0] MAIN_BASE = 22'h000000,
  parameter logic [21:0] OBJ_BASE  = 22'h002000,
  parameter logic [21:0] CHR_BASE  = 22'h004000
) (
  input  logic               clk,
  input  logic               rst_n,
  // main CPU ROM
  input  logic               main_cs,
  input  logic [MAIN_AW-1:0] main_addr,
  output logic [31:0]        main_data,
  output logic               main_ok,
  // object ROM
  input  logic               obj_cs,
  input  logic [OBJ_AW-1:0]  obj_addr,
  output logic [31:0]        obj_data,
  output logic               obj_ok,
  // character ROM
  input  logic               chr_cs,
  input  logic [CHR_AW-1:0]  chr_addr,
  output logic [31:0]        chr_data,
  output logic               chr_ok,
  // SDRAM controller
  output logic [21:0]        sdram_addr,
  output logic               sdram_req,
  input  logic               sdram_ack,
  input  logic               data_rdy,
  input  logic [31:0]        data_read
);

  localparam int c_TAG_W0 = (MAIN_AW > OBJ_AW) ? MAIN_AW : OBJ_AW;
  localparam int c_TAG_W  = (c_TAG_W0 > CHR_AW) ? c_TAG_W0 : CHR_AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_MAIN = 2'd0,
    SEL_OBJ  = 2'd1,
    SEL_CHR  = 2'd2
  } sel_t;

  state_t               r_state;
  sel_t                 r_sel;
  logic [c_TAG_W-1:0]   r_txn_tag;
  logic [21:0]          r_sdram_addr;
  logic                 r_sdram_req;

  logic                 r_main_valid;
  logic [MAIN_AW-1:0]   r_main_tag;
  logic [31:0]          r_main_data;
  logic                 r_obj_valid;
  logic [OBJ_AW-1:0]    r_obj_tag;
  logic [31:0]          r_obj_data;
  logic                 r_chr_valid;
  logic [CHR_AW-1:0]    r_chr_tag;
  logic [31:0]          r_chr_data;

  logic                 w_main_hit;
  logic                 w_obj_hit;
  logic                 w_chr_hit;
  logic                 w_main_pend;
  logic                 w_obj_pend;
  logic                 w_chr_pend;
  logic                 w_any_pend;
  logic [21:0]          w_main_sa;
  logic [21:0]          w_obj_sa;
  logic [21:0]          w_chr_sa;
  logic                 w_latch;
  logic                 w_main_we;
  logic                 w_obj_we;
  logic                 w_chr_we;

  // Hit / pending detection from the cache registers and live client inputs
  assign w_main_hit  = r_main_valid && (main_addr == r_main_tag);
  assign w_obj_hit   = r_obj_valid  && (obj_addr  == r_obj_tag);
  assign w_chr_hit   = r_chr_valid  && (chr_addr  == r_chr_tag);

  assign w_main_pend = main_cs && !w_main_hit;
  assign w_obj_pend  = obj_cs  && !w_obj_hit;
  assign w_chr_pend  = chr_cs  && !w_chr_hit;
  assign w_any_pend  = w_main_pend || w_obj_pend || w_chr_pend;

  assign w_main_sa   = MAIN_BASE + 22'(main_addr);
  assign w_obj_sa    = OBJ_BASE  + 22'(obj_addr);
  assign w_chr_sa    = CHR_BASE  + 22'(chr_addr);

  // Read data belongs to the outstanding transaction; ack+data together in REQ
  // is treated as ack immediately followed by data.
  assign w_latch   = ((r_state == ST_WAIT) && data_rdy) ||
                     ((r_state == ST_REQ) && sdram_ack && data_rdy);
  assign w_main_we = w_latch && (r_sel == SEL_MAIN);
  assign w_obj_we  = w_latch && (r_sel == SEL_OBJ);
  assign w_chr_we  = w_latch && (r_sel == SEL_CHR);

  assign main_ok    = main_cs && w_main_hit;
  assign obj_ok     = obj_cs  && w_obj_hit;
  assign chr_ok     = chr_cs  && w_chr_hit;
  assign main_data  = r_main_data;
  assign obj_data   = r_obj_data;
  assign chr_data   = r_chr_data;
  assign sdram_addr = r_sdram_addr;
  assign sdram_req  = r_sdram_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sel        <= SEL_MAIN;
      r_txn_tag    <= '0;
      r_sdram_addr <= '0;
      r_sdram_req  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_pend) begin
            r_sdram_req <= 1'b1;
            r_state     <= ST_REQ;
            if (w_main_pend) begin
              r_sel        <= SEL_MAIN;
              r_txn_tag    <= c_TAG_W'(main_addr);
              r_sdram_addr <= w_main_sa;
            end else if (w_obj_pend) begin
              r_sel        <= SEL_OBJ;
              r_txn_tag    <= c_TAG_W'(obj_addr);
              r_sdram_addr <= w_obj_sa;
            end else begin
              r_sel        <= SEL_CHR;
              r_txn_tag    <= c_TAG_W'(chr_addr);
              r_sdram_addr <= w_chr_sa;
            end
          end
        end
        ST_REQ: begin
          if (sdram_ack) begin
            r_sdram_req <= 1'b0;
            r_state     <= data_rdy ? ST_IDLE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (data_rdy) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_sdram_req <= 1'b0;
        end
      endcase
    end
  end

  // The stored tag is the address that was sent, even if the client moved on
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_main_tag   <= '0;
      r_main_data  <= '0;
    end else if (w_main_we) begin
      r_main_valid <= 1'b1;
      r_main_tag   <= r_txn_tag[MAIN_AW-1:0];
      r_main_data  <= data_read;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_obj_valid <= 1'b0;
      r_obj_tag   <= '0;
      r_obj_data  <= '0;
    end else if (w_obj_we) begin
      r_obj_valid <= 1'b1;
      r_obj_tag   <= r_txn_tag[OBJ_AW-1:0];
      r_obj_data  <= data_read;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chr_valid <= 1'b0;
      r_chr_tag   <= '0;
      r_chr_data  <= '0;
    end else if (w_chr_we) begin
      r_chr_valid <= 1'b1;
      r_chr_tag   <= r_txn_tag[CHR_AW-1:0];
      r_chr_data  <= data_read;
    end
  end

endmodule
`default_nettype wire
